// File: rtl/timed_phase_pkg.sv
// Shared types and helpers for the timed phase sequencer.
package timed_phase_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Phase index width: at least one bit even for a single-phase build.
  function automatic int phase_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tpf_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module tpf_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/timed_phase_fsm.sv
// Timed run sequencer: a run of timer+1 cycles during which nonzero data
// advances a wrapping phase index and is captured onto out.
module timed_phase_fsm
  import timed_phase_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               NPHASE   = 2,
  parameter logic [WIDTH-1:0] IDLE_OUT = WIDTH'(15)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            timer,
  input  logic [WIDTH-1:0]            data,
  input  logic                        abort,
  output logic [WIDTH-1:0]            out,
  output logic [phase_w(NPHASE)-1:0]  phase,
  output logic                        busy,
  output logic                        expired
);

  localparam int PW = phase_w(NPHASE);

  state_t           state_q, state_d;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic [WIDTH-1:0] cnt_load_val;
  logic [WIDTH-1:0] out_d;
  logic [PW-1:0]    phase_d;
  logic             expired_d;

  tpf_down_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (timer != '0) state_d = RUN;
      RUN:     if (abort || cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort outranks timeout, which outranks counting; the timeout cycle
  // never captures data.
  always_comb begin
    out_d        = out;
    phase_d      = phase;
    expired_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_load     = 1'b1;
        cnt_load_val = timer;
        phase_d      = '0;
        out_d        = IDLE_OUT;
      end
      RUN: begin
        if (abort) begin
          cnt_load = 1'b1;
          phase_d  = '0;
          out_d    = IDLE_OUT;
        end else if (cnt_zero) begin
          phase_d   = '0;
          out_d     = IDLE_OUT;
          expired_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (data != '0) begin
            phase_d = (phase == PW'(NPHASE - 1)) ? '0 : phase + PW'(1);
            out_d   = data;
          end
        end
      end
      default: begin
        phase_d = '0;
        out_d   = IDLE_OUT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= IDLE_OUT;
      phase   <= '0;
      expired <= 1'b0;
    end else begin
      out     <= out_d;
      phase   <= phase_d;
      expired <= expired_d;
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_timed_phase_fsm.sv
// Randomized and directed bench for timed_phase_fsm against a run-level model.
module tb_timed_phase_fsm;

  localparam int W      = 16;
  localparam int NPH    = 3;
  localparam int IDLEV  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  timer = '0;
  logic [W-1:0]  data = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  out;
  logic [1:0]    phase;
  logic          busy;
  logic          expired;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a run is "cycle pos of T+1"; phase is the advance count mod NPH.
  logic          m_busy = 1'b0;
  int            m_len  = 0;
  int            m_pos  = 0;
  int            m_adv  = 0;
  logic [W-1:0]  m_out  = W'(IDLEV);
  logic          m_exp  = 1'b0;
  logic [1:0]    m_phase = '0;

  timed_phase_fsm #(
    .WIDTH    (W),
    .NPHASE   (NPH),
    .IDLE_OUT (W'(IDLEV))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .timer   (timer),
    .data    (data),
    .abort   (abort),
    .out     (out),
    .phase   (phase),
    .busy    (busy),
    .expired (expired)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (!rst_n) begin
      m_busy = 1'b0; m_adv = 0; m_out = W'(IDLEV); m_exp = 1'b0;
    end else if (!m_busy) begin
      m_exp = 1'b0;
      m_out = W'(IDLEV);
      m_adv = 0;
      if (timer != 0) begin
        m_busy = 1'b1; m_len = int'(timer); m_pos = 0;
      end
    end else if (abort) begin
      m_busy = 1'b0; m_adv = 0; m_out = W'(IDLEV); m_exp = 1'b0;
    end else if (m_pos == m_len) begin
      m_busy = 1'b0; m_adv = 0; m_out = W'(IDLEV); m_exp = 1'b1;
    end else begin
      m_pos++;
      m_exp = 1'b0;
      if (data != 0) begin
        m_adv++;
        m_out = data;
      end
    end
    m_phase = 2'(m_adv % NPH);
  endtask

  task automatic tick(input logic r, input logic [W-1:0] t, input logic [W-1:0] d,
                      input logic a);
    rst_n = r; timer = t; data = d; abort = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, (i == 2) ? W'(5) : W'(0), W'(3), (i == 1));
      n_checks++;
      if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/0",
                 i, out, phase, busy, expired);
      end
    end
    tick(1'b1, W'(0), W'(0), 1'b0);
    n_checks++;
    if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/0",
               out, phase, busy, expired);
    end
  endtask

  task automatic test_basic();
    int nb = 0, ne = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i == 0) ? W'(3) : W'(0), W'(0), 1'b0);
      nb += int'(busy); ne += int'(expired);
      n_checks++;
      if ({out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp} || out !== W'(IDLEV)) begin
        n_fail++;
        $display("FAIL basic[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want %0d/%0d/%0b/%0b",
                 i, out, phase, busy, expired, m_out, m_phase, m_busy, m_exp);
      end
    end
    n_checks++;
    if (nb != 4 || ne != 1) begin
      n_fail++;
      $display("FAIL basic_counts: busy_cycles=%0d expired_pulses=%0d, want 4 and 1", nb, ne);
    end
  endtask

  task automatic test_phase_wrap();
    int exp_ph[6] = '{0, 1, 2, 0, 1, 2};
    int nb = 0, ne = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, (i == 0) ? W'(5) : W'(0), W'(7), 1'b0);
      if (busy && nb < 6) begin
        n_checks++;
        if (int'(phase) != exp_ph[nb] || (nb > 0 && out !== W'(7))) begin
          n_fail++;
          $display("FAIL wrap_phase[%0d]: phase=%0d out=%0d, want phase %0d out 7",
                   nb, phase, out, exp_ph[nb]);
        end
      end
      nb += int'(busy); ne += int'(expired);
      n_checks++;
      if ({out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want %0d/%0d/%0b/%0b",
                 i, out, phase, busy, expired, m_out, m_phase, m_busy, m_exp);
      end
    end
    n_checks++;
    if (nb != 6 || ne != 1) begin
      n_fail++;
      $display("FAIL wrap_counts: busy_cycles=%0d expired_pulses=%0d, want 6 and 1", nb, ne);
    end
  endtask

  task automatic test_abort();
    tick(1'b1, W'(10), W'(0), 1'b0);
    tick(1'b1, W'(0), W'(4), 1'b0);
    tick(1'b1, W'(0), W'(4), 1'b0);
    tick(1'b1, W'(0), W'(0), 1'b0);
    n_checks++;
    if (busy !== 1'b1 || out !== W'(4) || phase !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%0b out=%0d phase=%0d, want 1/4/2", busy, out, phase);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, W'(0), W'(4), (i == 0));
      n_checks++;
      if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b0} ||
          {out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp}) begin
        n_fail++;
        $display("FAIL abort[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/0",
                 i, out, phase, busy, expired);
      end
    end
  endtask

  task automatic test_timeout_data();
    tick(1'b1, W'(2), W'(0), 1'b0);
    tick(1'b1, W'(0), W'(0), 1'b0);
    tick(1'b1, W'(0), W'(0), 1'b0);
    tick(1'b1, W'(0), W'(9), 1'b0);
    n_checks++;
    if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b1} ||
        {out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp}) begin
      n_fail++;
      $display("FAIL timeout_data: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/1",
               out, phase, busy, expired);
    end
    tick(1'b1, W'(0), W'(0), 1'b0);
    n_checks++;
    if (expired !== 1'b0) begin
      n_fail++;
      $display("FAIL expired_width: exp=%0b one cycle later, want 0", expired);
    end
  endtask

  task automatic test_reset_mid_run();
    tick(1'b1, W'(16'hFFFF), W'(0), 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, W'(0), W'(i + 1), 1'b0);
    tick(1'b0, W'(0), W'(5), 1'b0);
    n_checks++;
    if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_run: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/0",
               out, phase, busy, expired);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, W'(0), W'(0), 1'b0);
      n_checks++;
      if ({out, phase, busy, expired} !== {W'(IDLEV), 2'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_run_after[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want 15/0/0/0",
                 i, out, phase, busy, expired);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb = 0, ne = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, W'(1), W'(0), 1'b0);
      nb += int'(busy); ne += int'(expired);
      n_checks++;
      if (busy !== ((i % 3) != 2) || expired !== ((i % 3) == 2) ||
          {out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp}) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: busy=%0b exp=%0b out=%0d, want busy %0b exp %0b",
                 i, busy, expired, out, ((i % 3) != 2), ((i % 3) == 2));
      end
    end
    n_checks++;
    if (nb != 8 || ne != 4) begin
      n_fail++;
      $display("FAIL back_to_back_counts: busy=%0d expired=%0d, want 8 and 4", nb, ne);
    end
    tick(1'b1, W'(0), W'(0), 1'b0);
    tick(1'b1, W'(0), W'(0), 1'b0);
  endtask

  task automatic test_random();
    logic         r, a;
    logic [W-1:0] t, d;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 63) != 0);
      t = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 6)) : W'(0);
      d = ($urandom_range(0, 1) == 0) ? W'(0) : W'($urandom);
      a = ($urandom_range(0, 19) == 0);
      tick(r, t, d, a);
      n_checks++;
      if ({out, phase, busy, expired} !== {m_out, m_phase, m_busy, m_exp}) begin
        n_fail++;
        $display("FAIL random[%0d]: out=%0d phase=%0d busy=%0b exp=%0b, want %0d/%0d/%0b/%0b",
                 i, out, phase, busy, expired, m_out, m_phase, m_busy, m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase_wrap();
    test_abort();
    test_timeout_data();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
